// File: rtl/verici_genel.sv
// verici_genel: word transmitter sending one parallel beat or N/K serial K-bit
// beats (MSB- or LSB-chunk first) over a valid/ready handshake.
module verici_genel #(
    parameter int unsigned N = 12,
    parameter int unsigned K = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         basla,
    input  logic         mod,
    input  logic         yon,
    input  logic [N-1:0] gelen_veri,
    input  logic         alici_hazir,
    output logic [N-1:0] cikan_veri,
    output logic         gecerli,
    output logic         bitti,
    output logic         mesgul
);

    localparam int unsigned BEATS = N / K;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [N-1:0] MASK = ~({N{1'b1}} << K);

    typedef enum logic {BOSTA, GONDER} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  sayac_q, sayac_d;
    logic [N-1:0]   veri_q, veri_d;
    logic           mod_q, mod_d;
    logic           yon_q, yon_d;
    logic [N-1:0]   cikan_q, cikan_d;
    logic           gecerli_q, gecerli_d;
    logic           bitti_q, bitti_d;
    logic           mesgul_q, mesgul_d;

    // Select beat i of a word; parallel mode (or K == N) yields the whole word.
    function automatic logic [N-1:0] beat_sec(input logic [N-1:0] w, input logic m,
                                              input logic y, input logic [CW-1:0] i);
        int unsigned sh;
        if (!m || BEATS == 1) return w;
        sh = y ? K * 32'(i) : N - K - K * 32'(i);
        return (w >> sh) & MASK;
    endfunction

    // State and output registers; reset discards any partial transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BOSTA;
            sayac_q   <= '0;
            veri_q    <= '0;
            mod_q     <= 1'b0;
            yon_q     <= 1'b0;
            cikan_q   <= '0;
            gecerli_q <= 1'b0;
            bitti_q   <= 1'b0;
            mesgul_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sayac_q   <= sayac_d;
            veri_q    <= veri_d;
            mod_q     <= mod_d;
            yon_q     <= yon_d;
            cikan_q   <= cikan_d;
            gecerli_q <= gecerli_d;
            bitti_q   <= bitti_d;
            mesgul_q  <= mesgul_d;
        end
    end

    // Next-state and next-output logic; bitti_q marks the beat on display as the last one.
    always_comb begin
        state_d   = state_q;
        sayac_d   = sayac_q;
        veri_d    = veri_q;
        mod_d     = mod_q;
        yon_d     = yon_q;
        cikan_d   = cikan_q;
        gecerli_d = gecerli_q;
        bitti_d   = bitti_q;
        mesgul_d  = mesgul_q;
        unique case (state_q)
            BOSTA: begin
                gecerli_d = 1'b0;
                bitti_d   = 1'b0;
                mesgul_d  = 1'b0;
                if (basla) begin
                    veri_d    = gelen_veri;
                    mod_d     = mod;
                    yon_d     = yon;
                    sayac_d   = '0;
                    cikan_d   = beat_sec(gelen_veri, mod, yon, '0);
                    gecerli_d = 1'b1;
                    mesgul_d  = 1'b1;
                    bitti_d   = !mod || (BEATS == 1);
                    state_d   = GONDER;
                end
            end
            GONDER: begin
                if (alici_hazir) begin
                    if (bitti_q) begin
                        gecerli_d = 1'b0;
                        bitti_d   = 1'b0;
                        mesgul_d  = 1'b0;
                        state_d   = BOSTA;
                    end else begin
                        sayac_d = sayac_q + CW'(1);
                        cikan_d = beat_sec(veri_q, mod_q, yon_q, sayac_d);
                        bitti_d = (sayac_d == CW'(BEATS - 1));
                    end
                end
            end
            default: state_d = BOSTA;
        endcase
    end

    assign cikan_veri = cikan_q;
    assign gecerli    = gecerli_q;
    assign bitti      = bitti_q;
    assign mesgul     = mesgul_q;

endmodule

// File: tb/tb_verici_genel.sv
// Bench for verici_genel: directed literal scenarios plus randomized traffic
// checked every cycle against a queue-based beat model.
module tb_verici_genel;

    localparam int unsigned N = 12;
    localparam int unsigned K = 3;
    localparam int unsigned BEATS = N / K;

    logic         clk = 1'b0;
    logic         rst;
    logic         basla, mod, yon, alici_hazir;
    logic [N-1:0] gelen_veri;
    logic [N-1:0] cikan_veri;
    logic         gecerli, bitti, mesgul;

    int n_cmp = 0;
    int n_bad = 0;

    verici_genel #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .basla(basla), .mod(mod), .yon(yon),
        .gelen_veri(gelen_veri), .alici_hazir(alici_hazir),
        .cikan_veri(cikan_veri), .gecerli(gecerli), .bitti(bitti), .mesgul(mesgul)
    );

    always #5 clk = ~clk;

    // Model: queue of beats still to be delivered; head is the beat on display.
    logic [N-1:0] mq[$];
    logic [N-1:0] m_out;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_out = '0;
        end else if (mq.size() > 0) begin
            if (alici_hazir) begin
                void'(mq.pop_front());
                if (mq.size() > 0) m_out = mq[0];
            end
        end else if (basla) begin
            if (!mod || K == N) begin
                mq.push_back(gelen_veri);
            end else begin
                for (int i = 0; i < int'(BEATS); i++) begin
                    logic [N-1:0] b;
                    b = '0;
                    for (int j = 0; j < int'(K); j++)
                        b[j] = yon ? gelen_veri[K*i + j] : gelen_veri[N - K*(i+1) + j];
                    mq.push_back(b);
                end
            end
            m_out = mq[0];
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("model cikan_veri", cikan_veri, m_out);
            chk("model gecerli", N'(gecerli), N'(mq.size() > 0));
            chk("model bitti", N'(bitti), N'(mq.size() == 1));
            chk("model mesgul", N'(mesgul), N'(mq.size() > 0));
        end
    end

    // Wait one edge and check outputs against literal values; returns at the next negedge.
    task automatic tick_chk(input string name, input logic [N-1:0] ev, input logic eg, input logic eb);
        @(posedge clk); #1;
        chk({name, " data"}, cikan_veri, ev);
        chk({name, " gecerli"}, N'(gecerli), N'(eg));
        chk({name, " bitti"}, N'(bitti), N'(eb));
        chk({name, " mesgul"}, N'(mesgul), N'(eg));
        @(negedge clk);
    endtask

    task automatic start(input logic m, input logic y, input logic [N-1:0] w);
        basla = 1'b1; mod = m; yon = y; gelen_veri = w;
    endtask

    initial begin
        rst = 1'b1; basla = 1'b0; mod = 1'b0; yon = 1'b0;
        gelen_veri = '0; alici_hazir = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset data", cikan_veri, '0);
        chk("reset flags", {9'd0, gecerli, bitti, mesgul}, '0);
        rst = 1'b0;
        @(negedge clk);

        // 1 parallel
        start(1'b0, 1'b0, 12'b011100010110);
        tick_chk("t1 beat", 12'b011100010110, 1'b1, 1'b1);
        basla = 1'b0;
        tick_chk("t1 idle", 12'b011100010110, 1'b0, 1'b0);

        // 2 serial MSB first
        start(1'b1, 1'b0, 12'b011100010110);
        tick_chk("t2 b0", 12'b011, 1'b1, 1'b0);
        basla = 1'b0;
        tick_chk("t2 b1", 12'b100, 1'b1, 1'b0);
        tick_chk("t2 b2", 12'b010, 1'b1, 1'b0);
        tick_chk("t2 b3", 12'b110, 1'b1, 1'b1);
        tick_chk("t2 idle", 12'b110, 1'b0, 1'b0);

        // 3 serial LSB first
        start(1'b1, 1'b1, 12'b000111010101);
        tick_chk("t3 b0", 12'b101, 1'b1, 1'b0);
        basla = 1'b0;
        tick_chk("t3 b1", 12'b010, 1'b1, 1'b0);
        tick_chk("t3 b2", 12'b111, 1'b1, 1'b0);
        tick_chk("t3 b3", 12'b000, 1'b1, 1'b1);
        tick_chk("t3 idle", 12'b000, 1'b0, 1'b0);

        // 4 backpressure on beat 100
        start(1'b1, 1'b0, 12'b011100010110);
        tick_chk("t4 b0", 12'b011, 1'b1, 1'b0);
        basla = 1'b0;
        tick_chk("t4 b1", 12'b100, 1'b1, 1'b0);
        alici_hazir = 1'b0;
        for (int i = 0; i < 3; i++) tick_chk("t4 hold", 12'b100, 1'b1, 1'b0);
        alici_hazir = 1'b1;
        tick_chk("t4 b2", 12'b010, 1'b1, 1'b0);
        tick_chk("t4 b3", 12'b110, 1'b1, 1'b1);
        tick_chk("t4 idle", 12'b110, 1'b0, 1'b0);

        // 5 basla ignored while busy, then abort by reset
        start(1'b1, 1'b0, 12'b011100010110);
        tick_chk("t5 b0", 12'b011, 1'b1, 1'b0);
        start(1'b0, 1'b1, 12'hFFF);
        tick_chk("t5 b1", 12'b100, 1'b1, 1'b0);
        basla = 1'b0;
        @(posedge clk); #3;
        chk("t5 b2 data", cikan_veri, 12'b010);
        rst = 1'b1;
        #1;
        chk("t5 rst data", cikan_veri, '0);
        chk("t5 rst flags", {9'd0, gecerli, bitti, mesgul}, '0);
        @(negedge clk);
        rst = 1'b0;
        start(1'b0, 1'b0, 12'hFFF);
        tick_chk("t5 par", 12'hFFF, 1'b1, 1'b1);
        basla = 1'b0;
        tick_chk("t5 idle", 12'hFFF, 1'b0, 1'b0);

        // 6 basla on final-beat edge ignored, next BOSTA cycle accepted
        start(1'b1, 1'b1, 12'b000111010101);
        tick_chk("t6 b0", 12'b101, 1'b1, 1'b0);
        basla = 1'b0;
        tick_chk("t6 b1", 12'b010, 1'b1, 1'b0);
        tick_chk("t6 b2", 12'b111, 1'b1, 1'b0);
        tick_chk("t6 b3", 12'b000, 1'b1, 1'b1);
        start(1'b0, 1'b0, 12'hABC);
        tick_chk("t6 ignored", 12'b000, 1'b0, 1'b0);
        tick_chk("t6 new", 12'hABC, 1'b1, 1'b1);
        basla = 1'b0;
        tick_chk("t6 idle", 12'hABC, 1'b0, 1'b0);

        // Randomized traffic with backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            basla       = ($urandom_range(0, 2) == 0);
            mod         = 1'($urandom);
            yon         = 1'($urandom);
            gelen_veri  = N'($urandom);
            alici_hazir = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; basla = 1'b0; alici_hazir = 1'b1;
        repeat (BEATS + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
